// File: rtl/car_draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : car_draw_scheduler
//  Description : Walks a table of car positions once per frame and drives the
//                20x20 sprite drawer for each valid, on-screen slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module car_draw_scheduler #(
    parameter int NUM_CARS       = 4,
    parameter int SCREEN_W       = 160,
    parameter int SCREEN_H       = 120,
    parameter int TIMEOUT_CYCLES = 2047,
    localparam int IDX_W         = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_tick,
    input  logic             pos_we,
    input  logic [IDX_W-1:0] pos_idx,
    input  logic [7:0]       pos_x,
    input  logic [6:0]       pos_y,
    input  logic             pos_valid,
    input  logic             draw_done,
    output logic             draw_enable,
    output logic [7:0]       draw_x,
    output logic [6:0]       draw_y,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [8:0]       c_X_MAX    = 9'(SCREEN_W - 20);
    localparam logic [7:0]       c_Y_MAX    = 8'(SCREEN_H - 20);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_CARS - 1);
    localparam logic [WD_W-1:0]  c_WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_DRAW   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WD_W-1:0]  r_wd;
    logic             r_tab_valid [NUM_CARS];
    logic [7:0]       r_tab_x     [NUM_CARS];
    logic [6:0]       r_tab_y     [NUM_CARS];

    logic w_slot_ok;
    logic w_idx_last;

    // Zero-extended compares so a large coordinate can never wrap into range.
    assign w_slot_ok  = r_tab_valid[r_idx]
                     && ({1'b0, r_tab_x[r_idx]} <= c_X_MAX)
                     && ({1'b0, r_tab_y[r_idx]} <= c_Y_MAX);
    assign w_idx_last = (r_idx == c_IDX_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_wd        <= '0;
            draw_enable <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) begin
                r_tab_valid[i] <= 1'b0;
                r_tab_x[i]     <= '0;
                r_tab_y[i]     <= '0;
            end
        end else begin
            frame_done <= 1'b0;

            if (pos_we && (int'(pos_idx) < NUM_CARS)) begin
                r_tab_valid[pos_idx] <= pos_valid;
                r_tab_x[pos_idx]     <= pos_x;
                r_tab_y[pos_idx]     <= pos_y;
            end

            if (frame_tick && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_slot_ok) begin
                        r_state <= S_LOAD;
                    end else if (w_idx_last) begin
                        r_state    <= S_FINISH;
                        frame_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_LOAD: begin
                    // Origin is captured here so later table writes wait for the next frame.
                    draw_x      <= r_tab_x[r_idx];
                    draw_y      <= r_tab_y[r_idx];
                    r_wd        <= '0;
                    draw_enable <= 1'b1;
                    r_state     <= S_DRAW;
                end
                S_DRAW: begin
                    if (draw_done) begin
                        draw_enable <= 1'b0;
                        r_state     <= S_GAP;
                    end else if (r_wd == c_WD_LAST) begin
                        draw_enable <= 1'b0;
                        timeout_err <= 1'b1;
                        r_state     <= S_GAP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_idx_last) begin
                        r_state    <= S_FINISH;
                        frame_done <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_FINISH: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_car_draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_draw_scheduler
//  Description : Scoreboard bench for car_draw_scheduler with a drawer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_car_draw_scheduler;

    localparam int NUM_CARS = 4;
    localparam int TIMEOUT  = 2047;
    localparam int X_MAX    = 160 - 20;
    localparam int Y_MAX    = 120 - 20;

    typedef struct {
        int kind;   // 0 = draw, 1 = frame_done
        int x;
        int y;
        int len;
        int at;
    } exp_t;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pos_we     = 1'b0;
    logic [1:0] pos_idx    = '0;
    logic [7:0] pos_x      = '0;
    logic [6:0] pos_y      = '0;
    logic       pos_valid  = 1'b0;
    logic       draw_done  = 1'b0;
    logic       draw_enable, busy, frame_done, overrun, timeout_err;
    logic [7:0] draw_x;
    logic [6:0] draw_y;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int fd_seen    = 0;
    int fd_expect  = 0;
    int drawer_dly = 1;

    bit   m_valid [NUM_CARS];
    int   m_x     [NUM_CARS];
    int   m_y     [NUM_CARS];
    exp_t exp_q[$];

    car_draw_scheduler #(
        .NUM_CARS(NUM_CARS), .SCREEN_W(160), .SCREEN_H(120), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .pos_we(pos_we),
        .pos_idx(pos_idx), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
        .draw_done(draw_done), .draw_enable(draw_enable), .draw_x(draw_x),
        .draw_y(draw_y), .busy(busy), .frame_done(frame_done), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drawer: raises draw_done for one cycle after drawer_dly enabled cycles; 0 = never.
    int dcnt = 0;
    always @(negedge clk) begin
        if (!resetn || !draw_enable) begin
            dcnt      = 0;
            draw_done = 1'b0;
        end else begin
            dcnt++;
            draw_done = (drawer_dly != 0) && (dcnt == drawer_dly);
        end
    end

    // Monitor: pops the scoreboard whenever a draw starts or a frame completes.
    bit   prev_en = 1'b0;
    int   en_len  = 0;
    int   len_exp = 0;
    int   hx = 0, hy = 0;
    exp_t mit;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_en = 1'b0;
            en_len  = 0;
        end else begin
            if (draw_enable && !prev_en) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
                    chk("unexpected draw_enable", 1, 0);
                    len_exp = -1;
                end else begin
                    mit = exp_q.pop_front();
                    chk("draw_x origin", int'(draw_x), mit.x);
                    chk("draw_y origin", int'(draw_y), mit.y);
                    len_exp = mit.len;
                end
                hx = int'(draw_x);
                hy = int'(draw_y);
                en_len = 1;
            end else if (draw_enable) begin
                en_len++;
                if (int'(draw_x) != hx || int'(draw_y) != hy) chk("origin stable", 0, 1);
            end
            if (!draw_enable && prev_en && len_exp >= 0) chk("enable length", en_len, len_exp);
            if (frame_done) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
                    chk("unexpected frame_done", 1, 0);
                end else begin
                    mit = exp_q.pop_front();
                    chk("frame_done cycle", cyc, mit.at);
                end
                fd_seen++;
            end
            prev_en = draw_enable;
        end
    end

    function automatic int draw_len(input int dly);
        return (dly == 0 || dly > TIMEOUT) ? TIMEOUT : dly;
    endfunction

    // Snapshot the table, predict every draw and the frame_done cycle, then tick.
    task automatic start_frame();
        exp_t e;
        int   at = cyc + 1;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (m_valid[i] && m_x[i] <= X_MAX && m_y[i] <= Y_MAX) begin
                e = '{kind: 0, x: m_x[i], y: m_y[i], len: draw_len(drawer_dly), at: 0};
                exp_q.push_back(e);
                at += draw_len(drawer_dly) + 3;
            end else begin
                at += 1;
            end
        end
        e = '{kind: 1, x: 0, y: 0, len: 0, at: at};
        exp_q.push_back(e);
        fd_expect++;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        while (fd_seen < fd_expect && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, fd_seen, fd_expect);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (!draw_enable && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, int'(draw_enable), 1);
    endtask

    task automatic write_slot(input int idx, input bit v, input int x, input int y);
        pos_we    = 1'b1;
        pos_idx   = 2'(idx);
        pos_valid = v;
        pos_x     = 8'(x);
        pos_y     = 7'(y);
        m_valid[idx] = v;
        m_x[idx]     = x;
        m_y[idx]     = y;
        @(posedge clk); #1;
        pos_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_CARS; i++) begin
            m_valid[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset draw_enable", int'(draw_enable), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset overrun", int'(overrun), 0);
        chk("reset timeout_err", int'(timeout_err), 0);
        chk("reset draw_x", int'(draw_x), 0);
        chk("reset draw_y", int'(draw_y), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Empty table: frame completes after one scan cycle per slot.
        start_frame();
        chk("busy after tick", int'(busy), 1);
        wait_frame("empty frame done");
        chk("busy idle", int'(busy), 0);

        // Two visible slots including the exact screen corner.
        drawer_dly = 1200;
        write_slot(0, 1'b1, 10, 20);
        write_slot(2, 1'b1, 140, 100);
        start_frame();
        wait_frame("two-slot frame done");

        // One pixel past each bound: skipped.
        write_slot(0, 1'b0, 10, 20);
        write_slot(2, 1'b0, 140, 100);
        write_slot(1, 1'b1, 141, 5);
        write_slot(3, 1'b1, 0, 101);
        start_frame();
        wait_frame("off-screen frame done");

        // Rewrite the slot being drawn and tick while busy.
        drawer_dly = 30;
        write_slot(1, 1'b0, 0, 0);
        write_slot(3, 1'b0, 0, 0);
        write_slot(0, 1'b1, 10, 20);
        chk("overrun before", int'(overrun), 0);
        start_frame();
        wait_enable("enable for overrun");
        pos_we = 1'b1; pos_idx = 2'd0; pos_valid = 1'b1; pos_x = 8'd50; pos_y = 7'd50;
        m_x[0] = 50; m_y[0] = 50;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        pos_we = 1'b0; frame_tick = 1'b0;
        @(posedge clk); #1;
        chk("draw_x held", int'(draw_x), 10);
        chk("overrun set", int'(overrun), 1);
        wait_frame("overrun frame done");
        start_frame();
        wait_frame("rewritten frame done");
        chk("overrun sticky", int'(overrun), 1);

        // Drawer never finishes: each draw is cut off by the watchdog.
        drawer_dly = 0;
        write_slot(0, 1'b0, 0, 0);
        write_slot(1, 1'b1, 0, 0);
        write_slot(2, 1'b1, 77, 33);
        chk("timeout_err before", int'(timeout_err), 0);
        start_frame();
        wait_frame("timeout frame done");
        chk("timeout_err set", int'(timeout_err), 1);

        // Reset in the middle of a draw.
        write_slot(1, 1'b0, 0, 0);
        write_slot(2, 1'b0, 0, 0);
        write_slot(0, 1'b1, 5, 5);
        start_frame();
        wait_enable("enable before reset");
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("reset drops draw_enable", int'(draw_enable), 0);
        chk("reset drops busy", int'(busy), 0);
        chk("reset clears overrun", int'(overrun), 0);
        chk("reset clears timeout_err", int'(timeout_err), 0);
        chk("reset no frame_done", int'(frame_done), 0);
        exp_q.delete();
        fd_expect = fd_seen;
        for (int i = 0; i < NUM_CARS; i++) m_valid[i] = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        drawer_dly = 10;
        start_frame();
        wait_frame("post-reset empty frame");

        // Randomized table contents and drawer latency.
        for (int r = 0; r < 10; r++) begin
            int nw = $urandom_range(1, 5);
            for (int w = 0; w < nw; w++) begin
                int xi = ($urandom_range(0, 1) == 1) ? $urandom_range(138, 143) : $urandom_range(0, 255);
                int yi = ($urandom_range(0, 1) == 1) ? $urandom_range(98, 103) : $urandom_range(0, 127);
                write_slot($urandom_range(0, NUM_CARS - 1), 1'($urandom_range(0, 3) != 0), xi, yi);
            end
            drawer_dly = $urandom_range(1, 40);
            start_frame();
            wait_frame("random frame done");
        end

        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

endmodule
`default_nettype wire
